// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by seq_alu and seq_alu_muldiv.
//   - aluc opcode constants (ALU_ADD ... ALU_DIVU).
//     Base ops have aluc[4]=0; bits marked x in the opcode map are ignored.
//   - state_e: the iterative engine FSM states.
//   - min_of(): the most negative two's-complement value for a given width.
// Optional feature macro used by this slice: SEQ_ALU_EARLY_OUT_EN (see seq_alu_muldiv).
package alu_pkg;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_AND   = 5'b00001;
  localparam logic [4:0] ALU_XOR   = 5'b00010;
  localparam logic [4:0] ALU_SLL   = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;
  localparam logic [4:0] ALU_OR    = 5'b00101;
  localparam logic [4:0] ALU_LUI   = 5'b00110;
  localparam logic [4:0] ALU_SRL   = 5'b00111;
  localparam logic [4:0] ALU_SRA   = 5'b01111;
  localparam logic [4:0] ALU_MULT  = 5'b10000;
  localparam logic [4:0] ALU_MULTU = 5'b10001;
  localparam logic [4:0] ALU_DIV   = 5'b10010;
  localparam logic [4:0] ALU_DIVU  = 5'b10011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int MAX_W = 128;

  // Only bit (w-1) set; callers truncate to their own width.
  function automatic logic [MAX_W-1:0] min_of(input int w);
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative multiply / divide engine with its FSM.
//   Multiply: shift-add, one multiplier bit per cycle.
//   Divide:   restoring, one quotient bit per cycle.
//   Signed ops run on magnitudes; signs are applied in ST_FIN.
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   launch             accepted only in ST_IDLE (the top gates it as well)
//   op                 aluc[1:0]: bit1 = divide, bit0 = unsigned
//   a, b               multiplicand/dividend, multiplier/divisor
//   hi, lo             registered results (product halves, or remainder/quotient)
//   busy               high while in ST_MUL or ST_DIV
//   done               one-cycle pulse on the cycle after ST_FIN
//   state              current FSM state (registered), for the top and for checkers
// Macro SEQ_ALU_EARLY_OUT_EN: when defined, ST_MUL exits as soon as the remaining
// multiplier bits are all zero; otherwise MUL always runs WIDTH iterations.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             launch,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output state_e           state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN = WIDTH'(min_of(WIDTH));

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;       // product accumulator
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]     mplier_q, mplier_d; // unprocessed multiplier bits
  logic [WIDTH-1:0]     rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0]     quo_q, quo_d;       // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]     dsr_q, dsr_d;       // divisor magnitude
  logic                 div_q, div_d;
  logic                 neg_q, neg_d;       // negate product / quotient
  logic                 rneg_q, rneg_d;     // negate remainder (dividend sign)
  logic                 dz_q, dz_d;         // divide by zero
  logic                 ovf_q, ovf_d;       // signed MIN / -1
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 is_signed;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       trial, diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 early;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    div_d    = div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    is_signed = ~op[0];
    mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;

    // Restoring step: no borrow means the divisor fits into the trial remainder.
    trial    = {rem_q, quo_q[WIDTH-1]};
    diff     = trial - {1'b0, dsr_q};

    prod_fix = neg_q  ? -acc_q : acc_q;
    quo_fix  = neg_q  ? -quo_q : quo_q;
    rem_fix  = rneg_q ? -rem_q : rem_q;

`ifdef SEQ_ALU_EARLY_OUT_EN
    early = (mplier_q == '0);
`else
    early = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d  = op[1] ? ST_DIV : ST_MUL;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          rem_d    = '0;
          quo_d    = mag_a;
          dsr_d    = mag_b;
          div_d    = op[1];
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d   = is_signed & a[WIDTH-1];
          dz_d     = (b == '0);
          ovf_d    = is_signed & op[1] & (a == MIN) & (b == '1);
        end
      end
      ST_MUL: begin
        // The counter-exhausted cycle is a plain hand-off to ST_FIN.
        if (cnt_q == LAST || early) begin
          state_d = ST_FIN;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == LAST) begin
          state_d = ST_FIN;
        end else begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          // Magnitude loop leaves |dividend| in rem; with its sign back it is the dividend.
          lo_d = '1;
          hi_d = rem_fix;
        end else if (ovf_q) begin
          lo_d = MIN;
          hi_d = '0;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered EXE-stage ALU with iterative multiply/divide.
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   start, aluc    launch the operation aluc on a, b
//   a, b           operands (a[SHW-1:0] is the shift amount for shifts)
//   s              registered single-cycle result
//   hi, lo         multiply high/low halves, or remainder/quotient
//   busy, done     engine busy; one-cycle result-valid pulse
// Handshake: start is taken only while the engine is idle (busy=0 and not in
// its final cycle); a refused start is dropped, never queued. Each accepted
// start yields exactly one done pulse: base ops on the cycle after the start
// edge, multiply/divide once hi/lo are written.
// Macro SEQ_ALU_EARLY_OUT_EN: early multiply exit inside seq_alu_muldiv.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       aluc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_e           md_state;
  logic             md_done;
  logic             is_ext, idle, base_go, launch;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] base_res, sra_res;
  logic [WIDTH-1:0] s_q, s_d;
  logic             base_done_q, base_done_d;

  // 1x1xx codes are reserved and fall back to base ops producing zero.
  assign is_ext  = aluc[4] & ~aluc[2];
  assign idle    = (md_state == ST_IDLE);
  assign base_go = start & idle & ~is_ext;
  assign launch  = start & idle & is_ext;
  assign sh      = a[SHW-1:0];

  // Kept on its own so the arithmetic shift is not turned unsigned by context.
  assign sra_res = $signed(b) >>> sh;

  always_comb begin
    base_res = '0;
    if (!aluc[4]) begin
      case (aluc[2:0])
        ALU_ADD[2:0]: base_res = a + b;
        ALU_SUB[2:0]: base_res = a - b;
        ALU_AND[2:0]: base_res = a & b;
        ALU_OR[2:0]:  base_res = a | b;
        ALU_XOR[2:0]: base_res = a ^ b;
        ALU_LUI[2:0]: base_res = b << (WIDTH / 2);
        ALU_SLL[2:0]: base_res = (aluc[3:0] == ALU_SLL[3:0]) ? (b << sh) : '0;
        ALU_SRL[2:0]: base_res = (aluc[3:0] == ALU_SRA[3:0]) ? sra_res : (b >> sh);
        default:      base_res = '0;
      endcase
    end
  end

  always_comb begin
    s_d         = s_q;
    base_done_d = base_go;
    if (base_go) s_d = base_res;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_q         <= '0;
      base_done_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      base_done_q <= base_done_d;
    end
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .launch (launch),
    .op     (aluc[1:0]),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (md_done),
    .state  (md_state)
  );

  assign s    = s_q;
  // Both sources are flops and can never pulse in the same cycle.
  assign done = base_done_q | md_done;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random stimulus for seq_alu at WIDTH=32, with an
// expected-result queue filled at launch and drained when done is seen.
// Latency expectations follow SEQ_ALU_EARLY_OUT_EN when it is defined.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = W'(min_of(W));

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         start;
  logic [4:0]   aluc;
  logic [W-1:0] a, b, s, hi, lo;
  logic         busy, done;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_s;

  logic [4:0]   bb_op [4] = '{ALU_ADD, ALU_XOR, ALU_SLL, ALU_LUI};
  logic [W-1:0] bb_a  [4] = '{32'd10, 32'hF0F0_F0F0, 32'd40, 32'd0};
  logic [W-1:0] bb_b  [4] = '{32'd20, 32'h0FF0_0FF0, 32'h0000_0003, 32'h0000_ABCD};
  logic [4:0]   base_codes [12] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI,
                                    ALU_SLL, ALU_SRL, ALU_SRA, 5'b01011, 5'b10100, 5'b11111};
  logic [4:0]   ext_codes [4] = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};

  seq_alu #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .aluc  (aluc),
    .a     (a),
    .b     (b),
    .s     (s),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference models
  function automatic logic [W-1:0] base_model(input logic [4:0] op, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    logic [4:0] sh;
    sh = x[4:0];
    if (op[4]) return '0;
    casez (op[3:0])
      4'b?000: return x + y;
      4'b?100: return x - y;
      4'b?001: return x & y;
      4'b?101: return x | y;
      4'b?010: return x ^ y;
      4'b?110: return {y[15:0], 16'h0000};
      4'b0011: return y << sh;
      4'b0111: return y >> sh;
      4'b1111: return W'($signed(y) >>> sh);
      default: return '0;
    endcase
  endfunction

  task automatic ext_model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] eh, output logic [W-1:0] el);
    longint p;
    longint unsigned pu;
    int sx, sy;
    sx = x;
    sy = y;
    eh = '0;
    el = '0;
    case (op[1:0])
      2'b00: begin p = longint'(sx) * longint'(sy); {eh, el} = p; end
      2'b01: begin pu = 64'(x) * 64'(y); {eh, el} = pu; end
      2'b10: begin
        if (y == '0) begin el = '1; eh = x; end
        else if (x == MIN && y == '1) begin el = MIN; eh = '0; end
        else begin el = sx / sy; eh = sx % sy; end
      end
      default: begin
        if (y == '0) begin el = '1; eh = x; end
        else begin el = x / y; eh = x % y; end
      end
    endcase
  endtask

  // Posedges from the start edge to the edge that raises done.
  function automatic int ext_lat(input logic [4:0] op, input logic [W-1:0] y);
    logic [W-1:0] mag;
    int n;
    if (op[1]) return W + 2;
    mag = (!op[0] && y[W-1]) ? -y : y;
    n = 0;
    for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
`ifdef SEQ_ALU_EARLY_OUT_EN
    return 2 + n;
`else
    return (n >= 0) ? W + 2 : 0;
`endif
  endfunction

  // driver tasks
  task automatic base_op(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    start = 1'b1; aluc = op; a = x; b = y;
    exp_q.push_back(base_model(op, x, y));
    @(negedge clock);
    start = 1'b0;
    check($sformatf("base_done op=%b", op), done, 1);
    check($sformatf("base_busy op=%b", op), busy, 0);
    last_s = exp_q.pop_front();
    check($sformatf("base_s op=%b a=%h b=%h", op, x, y), s, last_s);
    @(negedge clock);
    check("base_done_pulse", done, 0);
  endtask

  // poke >= 0 also tries an ADD start at that cycle and in the final (FIN) cycle.
  task automatic ext_op(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int poke);
    logic [W-1:0] eh, el;
    int lat, busy_n, elat;
    ext_model(op, x, y, eh, el);
    exp_q.push_back(eh);
    exp_q.push_back(el);
    elat = ext_lat(op, y);
    @(negedge clock);
    start = 1'b1; aluc = op; a = x; b = y;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (done !== 1'b1 && lat < W + 10) begin
      if (busy === 1'b1) busy_n++;
      if (poke >= 0 && (lat == poke || lat == elat - 1)) begin
        start = 1'b1; aluc = ALU_ADD; a = $urandom; b = $urandom;
      end
      @(negedge clock);
      start = 1'b0;
      lat++;
    end
    check($sformatf("ext_latency op=%b b=%h", op, y), lat, elat);
    check($sformatf("ext_busy_cycles op=%b", op), busy_n, elat - 1);
    check($sformatf("ext_hi op=%b a=%h b=%h", op, x, y), hi, exp_q.pop_front());
    check($sformatf("ext_lo op=%b a=%h b=%h", op, x, y), lo, exp_q.pop_front());
    check("ext_s_kept", s, last_s);
    check("ext_busy_at_done", busy, 0);
    @(negedge clock);
    check("ext_done_pulse", done, 0);
  endtask

  initial begin
    int seen;
    logic [4:0] rop;
    reset = 1'b1; start = 1'b0; aluc = '0; a = '0; b = '0;
    last_s = '0;
    repeat (2) @(negedge clock);
    check("rst_s", s, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // base ops
    base_op(ALU_ADD, 32'd5, 32'd3);
    check("add_5_3_const", s, 32'd8);
    base_op(ALU_SRA, 32'd36, 32'h8000_0000);
    check("sra_const", s, 32'hF800_0000);
    base_op(ALU_SUB, 32'd3, 32'd5);
    base_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    base_op(ALU_LUI, 32'd0, 32'h0000_1234);
    base_op(ALU_SRL, 32'd33, 32'h8000_0000);
    base_op(5'b01011, 32'd1, 32'd1);
    base_op(5'b10100, 32'd7, 32'd9);
    base_op(5'b11000 | ALU_SUB, 32'd9, 32'd4);

    // back-to-back base starts
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; aluc = bb_op[i]; a = bb_a[i]; b = bb_b[i];
      exp_q.push_back(base_model(bb_op[i], bb_a[i], bb_b[i]));
      @(negedge clock);
      check("b2b_done", done, 1);
      last_s = exp_q.pop_front();
      check("b2b_s", s, last_s);
    end
    start = 1'b0;
    @(negedge clock);

    // multiply
    ext_op(ALU_MULT, -32'sd3, 32'd7, -1);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFEB);
    ext_op(ALU_MULTU, 32'd1000, 32'd3, -1);
    ext_op(ALU_MULTU, 32'd123, 32'd0, -1);
    ext_op(ALU_MULT, MIN, MIN, -1);
    ext_op(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);

    // divide corners
    ext_op(ALU_DIV, -32'sd7, 32'd2, -1);
    ext_op(ALU_DIV, 32'd7, -32'sd2, -1);
    ext_op(ALU_DIVU, 32'd9, 32'd0, -1);
    ext_op(ALU_DIV, -32'sd7, 32'd0, -1);
    ext_op(ALU_DIV, MIN, 32'hFFFF_FFFF, -1);
    check("div_ovf_lo_const", lo, 32'h8000_0000);

    // start while busy and in the final cycle
    ext_op(ALU_DIVU, 32'd100, 32'd7, 5);
    check("divu_hi_const", hi, 32'd2);
    check("divu_lo_const", lo, 32'd14);

    // random
    for (int i = 0; i < 8; i++) begin
      rop = base_codes[$urandom_range(0, 11)];
      base_op(rop, $urandom, $urandom);
    end
    for (int i = 0; i < 8; i++) begin
      rop = ext_codes[$urandom_range(0, 3)];
      ext_op(rop, $urandom, (i % 2 == 1) ? 32'($urandom_range(0, 255)) : $urandom, -1);
    end

    // reset mid-operation
    base_op(ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    ext_op(ALU_MULT, -32'sd3, 32'd7, -1);
    @(negedge clock);
    start = 1'b1; aluc = ALU_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    check("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_s", s, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    last_s = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) seen++;
    end
    check("no_done_after_reset", seen, 0);
    base_op(ALU_ADD, 32'd5, 32'd3);
    ext_op(ALU_DIVU, 32'd100, 32'd7, -1);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
